// File: rtl/button_debouncer.sv
// Pushbutton conditioner: two-flop synchroniser plus a per-channel debounce FSM
// that produces a clean level and single-cycle press, release and long-press pulses.
module button_debouncer #(
    parameter int N_BTN       = 4,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int DEB_CYCLES  = 4500000,
    parameter int LONG_CYCLES = 450000000
) (
    input  logic             osc_clk,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} state_t;

    logic [N_BTN-1:0] sync1_q, sync2_q, raw_act;
    state_t           state_q    [N_BTN];
    state_t           state_d    [N_BTN];
    logic [DW-1:0]    deb_cnt_q  [N_BTN];
    logic [DW-1:0]    deb_cnt_d  [N_BTN];
    logic [HW-1:0]    hold_cnt_q [N_BTN];
    logic [HW-1:0]    hold_cnt_d [N_BTN];
    logic [N_BTN-1:0] long_done_q, long_done_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] long_q, long_d;

    assign raw_act = sync2_q ^ {N_BTN{ACTIVE_LOW}};

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (raw_act[i]) begin
                        state_d[i]   = ARM_P;
                        deb_cnt_d[i] = '0;
                    end
                end
                ARM_P: begin
                    if (!raw_act[i]) begin
                        state_d[i] = IDLE;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        state_d[i]    = HELD;
                        level_d[i]    = 1'b1;
                        press_d[i]    = 1'b1;
                        hold_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                    end
                end
                HELD: begin
                    if (hold_cnt_q[i] != LONG_LAST) begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                    end
                    // Long check and release arming may both fire in the same cycle
                    if (hold_cnt_q[i] == LONG_LAST && !long_done_q[i]) begin
                        long_d[i]      = 1'b1;
                        long_done_d[i] = 1'b1;
                    end
                    if (!raw_act[i]) begin
                        state_d[i]   = ARM_R;
                        deb_cnt_d[i] = '0;
                    end
                end
                ARM_R: begin
                    if (raw_act[i]) begin
                        state_d[i] = HELD;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        state_d[i]     = IDLE;
                        level_d[i]     = 1'b0;
                        release_d[i]   = 1'b1;
                        long_done_d[i] = 1'b0;
                        hold_cnt_d[i]  = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Synchroniser resets to the idle pin level so reset release never looks like a press
    always_ff @(posedge osc_clk or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= {N_BTN{ACTIVE_LOW}};
            sync2_q     <= {N_BTN{ACTIVE_LOW}};
            long_done_q <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]    <= IDLE;
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= BTN;
            sync2_q     <= sync1_q;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]    <= state_d[i];
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign BTN_LEVEL   = level_q;
    assign BTN_PRESS   = press_q;
    assign BTN_RELEASE = release_q;
    assign BTN_LONG    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios with fixed edge timing, then random
// pin activity compared cycle by cycle against a run-length based reference model.
module tb_button_debouncer;

    localparam int N  = 4;
    localparam bit AL = 1'b1;
    localparam int D  = 8;
    localparam int L  = 32;

    logic         osc_clk = 1'b0;
    logic         RST_N;
    logic [N-1:0] BTN;
    logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 osc_clk = ~osc_clk;

    button_debouncer #(
        .N_BTN(N), .ACTIVE_LOW(AL), .DEB_CYCLES(D), .LONG_CYCLES(L)
    ) dut (
        .osc_clk(osc_clk), .RST_N(RST_N), .BTN(BTN),
        .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE), .BTN_LONG(BTN_LONG)
    );

    // Model: a change is accepted after D+1 consecutive samples that disagree with the
    // level; hold time accrues only while the pressed level is undisputed.
    typedef struct packed {
        logic level;
        logic fired;
        logic press;
        logic rel;
        logic lng;
        int   run;
        int   held;
    } mch_t;

    logic [N-1:0] m_pipe1, m_pipe2;
    mch_t         m_ch [N];
    logic [N-1:0] exp_level, exp_press, exp_release, exp_long;

    function automatic mch_t step_ch(mch_t c, logic act);
        mch_t n = c;
        n.press = 1'b0;
        n.rel   = 1'b0;
        n.lng   = 1'b0;
        if (c.level && c.run == 0) begin
            if (c.held == L - 1 && !c.fired) begin
                n.lng   = 1'b1;
                n.fired = 1'b1;
            end
            if (c.held < L - 1) n.held = c.held + 1;
        end
        if (act != c.level) n.run = c.run + 1;
        else                n.run = 0;
        if (n.run == D + 1) begin
            n.run  = 0;
            n.held = 0;
            if (c.level) begin
                n.rel   = 1'b1;
                n.fired = 1'b0;
            end else begin
                n.press = 1'b1;
            end
            n.level = ~c.level;
        end
        return n;
    endfunction

    always @(posedge osc_clk or negedge RST_N) begin
        if (!RST_N) begin
            m_pipe1 <= {N{AL}};
            m_pipe2 <= {N{AL}};
            for (int i = 0; i < N; i++) m_ch[i] <= '0;
        end else begin
            m_pipe1 <= BTN;
            m_pipe2 <= m_pipe1;
            for (int i = 0; i < N; i++) m_ch[i] <= step_ch(m_ch[i], m_pipe2[i] ^ AL);
        end
    end

    always_comb begin
        exp_level   = '0;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        for (int i = 0; i < N; i++) begin
            exp_level[i]   = m_ch[i].level;
            exp_press[i]   = m_ch[i].press;
            exp_release[i] = m_ch[i].rel;
            exp_long[i]    = m_ch[i].lng;
        end
    end

    task automatic tick();
        @(posedge osc_clk);
        @(negedge osc_clk);
    endtask

    task automatic test_reset();
        BTN = '1;
        repeat (3) @(negedge osc_clk);
        n_checks++;
        if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG} !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000",
                     {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG});
        end
        RST_N = 1'b1;
    endtask

    task automatic test_idle();
        BTN = '1;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_checks++;
            if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG} !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL idle_quiet k=%0d: got %h expected 0000", k,
                         {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG});
            end
        end
    endtask

    task automatic test_press_release();
        BTN[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (BTN_PRESS[0] !== (k == 10) || BTN_LEVEL[0] !== (k >= 10) || BTN_RELEASE[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL press_timing k=%0d: got press=%b level=%b rel=%b expected press=%b level=%b rel=0",
                         k, BTN_PRESS[0], BTN_LEVEL[0], BTN_RELEASE[0], k == 10, k >= 10);
            end
        end
        BTN[0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (BTN_RELEASE[0] !== (k == 10) || BTN_LEVEL[0] !== (k < 10) || BTN_PRESS[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL release_timing k=%0d: got rel=%b level=%b press=%b expected rel=%b level=%b press=0",
                         k, BTN_RELEASE[0], BTN_LEVEL[0], BTN_PRESS[0], k == 10, k < 10);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 80; k++) begin
            BTN[1] = (k < 60) ? (((k / 3) % 2) != 0) : 1'b1;
            tick();
            n_checks++;
            if ({BTN_LEVEL[1], BTN_PRESS[1], BTN_RELEASE[1], BTN_LONG[1]} !== 4'h0) begin
                n_fail++;
                $display("[TB] FAIL bounce_reject k=%0d: got %b expected 0000", k,
                         {BTN_LEVEL[1], BTN_PRESS[1], BTN_RELEASE[1], BTN_LONG[1]});
            end
        end
    endtask

    task automatic test_long();
        int longs = 0;
        int rels  = 0;
        BTN[2] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_checks++;
            if (BTN_PRESS[2] !== (k == 10) || BTN_LONG[2] !== (k == 42)) begin
                n_fail++;
                $display("[TB] FAIL long_timing k=%0d: got press=%b long=%b expected press=%b long=%b",
                         k, BTN_PRESS[2], BTN_LONG[2], k == 10, k == 42);
            end
        end
        for (int k = 0; k < 64; k++) begin
            BTN[2] = (k < 4);
            tick();
            longs += int'(BTN_LONG[2]);
            rels  += int'(BTN_RELEASE[2]);
            n_checks++;
            if (BTN_LEVEL[2] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL glitch_level k=%0d: got %b expected 1", k, BTN_LEVEL[2]);
            end
        end
        n_checks++;
        if (longs != 0 || rels != 0) begin
            n_fail++;
            $display("[TB] FAIL no_second_long: got longs=%0d rels=%0d expected 0 0", longs, rels);
        end
        BTN[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            rels += int'(BTN_RELEASE[2]);
        end
        n_checks++;
        if (rels != 1 || BTN_LEVEL[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL final_release: got rels=%0d level=%b expected 1 0", rels, BTN_LEVEL[2]);
        end
    endtask

    task automatic test_simultaneous();
        BTN = 4'h0;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (BTN_PRESS !== ((k == 10) ? 4'hF : 4'h0) || BTN_LEVEL !== ((k >= 10) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("[TB] FAIL simul_press k=%0d: got press=%h level=%h", k, BTN_PRESS, BTN_LEVEL);
            end
        end
        BTN = 4'hF;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (BTN_RELEASE !== ((k == 10) ? 4'hF : 4'h0) || BTN_LEVEL !== ((k < 10) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("[TB] FAIL simul_release k=%0d: got rel=%h level=%h", k, BTN_RELEASE, BTN_LEVEL);
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        BTN[0] = 1'b0;
        while (BTN_LEVEL[0] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (BTN_LEVEL[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_wait: got level=%b expected 1 within 20 cycles", BTN_LEVEL[0]);
        end
        RST_N = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG} !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL midreset_outputs k=%0d: got %h expected 0000", k,
                         {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG});
            end
            tick();
        end
        RST_N = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (BTN_PRESS[0] !== (k == 10) || BTN_LEVEL[0] !== (k >= 10)) begin
                n_fail++;
                $display("[TB] FAIL midreset_repress k=%0d: got press=%b level=%b expected press=%b level=%b",
                         k, BTN_PRESS[0], BTN_LEVEL[0], k == 10, k >= 10);
            end
        end
        BTN = '1;
        repeat (15) tick();
    endtask

    task automatic test_random();
        int rem [N];
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    BTN[i] = 1'($urandom_range(0, 1));
                    rem[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12))
                                                         : int'($urandom_range(10, 80));
                end
                rem[i]--;
            end
            if (c == 1200) RST_N = 1'b0;
            if (c == 1203) RST_N = 1'b1;
            tick();
            n_checks++;
            if (BTN_LEVEL !== exp_level || BTN_PRESS !== exp_press ||
                BTN_RELEASE !== exp_release || BTN_LONG !== exp_long) begin
                n_fail++;
                $display("[TB] FAIL random_model c=%0d: got lvl=%h pr=%h rl=%h lg=%h expected lvl=%h pr=%h rl=%h lg=%h",
                         c, BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG,
                         exp_level, exp_press, exp_release, exp_long);
            end
            n_checks++;
            if ((BTN_PRESS & BTN_RELEASE) !== 4'h0) begin
                n_fail++;
                $display("[TB] FAIL press_release_overlap c=%0d: got %h expected 0", c, BTN_PRESS & BTN_RELEASE);
            end
        end
    endtask

    initial begin
        RST_N = 1'b1;
        BTN   = '1;
        #2 RST_N = 1'b0;
        test_reset();
        test_idle();
        test_press_release();
        test_bounce();
        test_long();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
